// File: rtl/tt_lut_engine.sv
// Programmable N_IN-input LUT with chunked table load,
// streamed evaluation and an in-system truth-table sweep.
module tt_lut_engine #(
  parameter  int N_IN   = 4,
  parameter  int LOAD_W = 8,
  localparam int TT_W   = 2**N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LOAD_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              cfg_err,
  output logic              tt_loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [TT_W-1:0]   sweep_tt
);

  localparam int NCH = TT_W / LOAD_W;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((TT_W % LOAD_W) != 0) begin : g_bad_load_w
    $error("TT_W must be an integer multiple of LOAD_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t          state;
  logic [N_IN-1:0] k;
  logic [TT_W-1:0] active_tt;
  logic [TT_W-1:0] shadow_tt;
  logic [TT_W-1:0] shadow_nxt;
  logic [CW-1:0]   cnt;
  logic            last_pos;
  logic            cfg_acc;
  logic            in_acc;

  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == DONE);
  assign cfg_ready  = (state != SWEEP);
  assign in_ready   = !sweep_busy &&
                      (!out_valid || out_ready);
  assign cfg_acc    = cfg_valid && cfg_ready;
  assign in_acc     = in_valid && in_ready;
  assign last_pos   = (cnt == CW'(NCH - 1));

  // Shadow table with the incoming chunk merged at its slot
  always_comb begin
    shadow_nxt = shadow_tt;
    shadow_nxt[int'(cnt)*LOAD_W +: LOAD_W] = cfg_data;
  end

  // Chunked load with framing check and atomic commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_tt <= '0;
      shadow_tt <= '0;
      cnt       <= '0;
      cfg_err   <= 1'b0;
      tt_loaded <= 1'b0;
    end else if (cfg_acc) begin
      if (cfg_last && last_pos) begin
        active_tt <= shadow_nxt;
        tt_loaded <= 1'b1;
        shadow_tt <= '0;
        cnt       <= '0;
      end else if (cfg_last || last_pos) begin
        cfg_err   <= 1'b1;
        shadow_tt <= '0;
        cnt       <= '0;
      end else begin
        shadow_tt <= shadow_nxt;
        cnt       <= cnt + CW'(1);
      end
    end
  end

  // One-stage evaluation pipeline with backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else if (in_acc) begin
      out_valid <= 1'b1;
      out_bit   <= active_tt[in_vec];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sweep FSM: copy the active table bit by bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      sweep_tt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sweep_start && !out_valid) begin
            state <= SWEEP;
            k     <= '0;
          end
        end
        SWEEP: begin
          sweep_tt[k] <= active_tt[k];
          k           <= k + 1'b1;
          if (k == '1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
